// File: rtl/wb_ram_bist_pkg.sv
// Shared types and helpers for the Wishbone RAM BIST initiator.
// Optional feature macro: WB_RAM_BIST_ERRCNT_EN (see wb_ram_bist_master).
package wb_ram_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      GAP,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      P0_W,
      P1_R,
      P1_W,
      P2_R
   } phase_t;

   localparam logic [31:0] PATTERN_KEY = 32'hA5A5_A5A5;

   // Data written in P0 and expected in P1_R; its inverse is used in P1_W/P2_R.
   function automatic logic [31:0] pattern(input logic [7:0] a);
      return {4{a}} ^ PATTERN_KEY;
   endfunction

endpackage

// File: rtl/wb_ram_bist_addr_gen.sv
// 8-bit word-address counter for the BIST: load, step up or down, and a
// terminal-count flag (255 when counting up, 0 when counting down).
module wb_ram_bist_addr_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       step,
   input  logic       up,
   output logic [7:0] addr,
   output logic       last
);

   // Address register: load has priority over step; never wraps in use
   // because the controller stops stepping at the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge value of its neighbours.
      if (!rst_n) begin
         addr <= 8'd0;
      end else if (load) begin
         addr <= load_val;
      end else if (step) begin
         addr <= up ? addr + 8'd1 : addr - 8'd1;
      end
   end

   assign last = up ? (addr == 8'hFF) : (addr == 8'h00);

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone classic initiator running a March-style self-test over a
// 256-word, 32-bit RAM: write P(a), read P(a)/write ~P(a), read ~P(a)
// descending. Reports pass/fail, timeout and the first failing word.
// Optional feature macro: WB_RAM_BIST_ERRCNT_EN -- when defined, a
// miscompare does not stop the test and err_count_o counts all of them.
module wb_ram_bist_master
   import wb_ram_bist_pkg::*;
#(
   parameter int         ADDR_WIDTH = 10,
   parameter logic [3:0] TIMEOUT    = 4'd15
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [7:0]            fail_addr_o,
   output logic [31:0]           fail_data_o,
`ifdef WB_RAM_BIST_ERRCNT_EN
   output logic [10:0]           err_count_o,
`endif
   output logic                  wbm_cyc_o,
   output logic                  wbm_stb_o,
   output logic                  wbm_we_o,
   output logic [3:0]            wbm_sel_o,
   output logic [ADDR_WIDTH-1:0] wbm_adr_o,
   output logic [31:0]           wbm_dat_o,
   input  logic                  wbm_ack_i,
   input  logic [31:0]           wbm_dat_i
);

`ifdef WB_RAM_BIST_ERRCNT_EN
   localparam bit STOP_ON_MISS = 1'b0;
`else
   localparam bit STOP_ON_MISS = 1'b1;
`endif

   state_t      state, next_state;
   phase_t      phase;
   logic [3:0]  tcnt;
   logic        err_seen;
   logic        timeout_r;
   logic [7:0]  fail_addr_r;
   logic [31:0] fail_data_r;

   logic        ag_load, ag_step, ag_up, ag_last;
   logic [7:0]  ag_load_val, addr;

   logic        start_test, is_read, miscompare, tmo_hit;
   logic [31:0] expected;

   assign start_test = ((state == IDLE) || (state == DONE)) && start_i;
   assign is_read    = (phase == P1_R) || (phase == P2_R);
   assign expected   = (phase == P2_R) ? ~pattern(addr) : pattern(addr);
   assign miscompare = (state == ACCESS) && wbm_ack_i && is_read && (wbm_dat_i != expected);
   assign tmo_hit    = (state == ACCESS) && !wbm_ack_i && (tcnt == TIMEOUT);

   wb_ram_bist_addr_gen u_addr_gen (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .load     (ag_load),
      .load_val (ag_load_val),
      .step     (ag_step),
      .up       (ag_up),
      .addr     (addr),
      .last     (ag_last)
   );

   // State register; async reset drops cyc/stb at once since they decode state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state <= IDLE;
      else             state <= next_state;
   end

   // Next-state logic: ack beats timeout; a stopping miscompare skips GAP.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_state unassigned
      // and no latch is inferred.
      next_state = state;
      case (state)
         IDLE, DONE: if (start_i) next_state = ACCESS;
         ACCESS: begin
            if (wbm_ack_i)    next_state = (miscompare && STOP_ON_MISS) ? DONE : GAP;
            else if (tmo_hit) next_state = DONE;
         end
         GAP:     next_state = ((phase == P2_R) && ag_last) ? DONE : ACCESS;
         default: next_state = IDLE;
      endcase
   end

   // Bus and status outputs decoded from state; address/data held by phase/addr.
   always_comb begin
      wbm_cyc_o   = 1'b0;
      wbm_stb_o   = 1'b0;
      wbm_we_o    = 1'b0;
      wbm_sel_o   = 4'h0;
      wbm_adr_o   = '0;
      wbm_dat_o   = 32'd0;
      busy_o      = (state == ACCESS) || (state == GAP);
      done_o      = (state == DONE);
      pass_o      = (state == DONE) && !err_seen && !timeout_r;
      timeout_o   = timeout_r;
      fail_addr_o = fail_addr_r;
      fail_data_o = fail_data_r;
      if (state == ACCESS) begin
         wbm_cyc_o = 1'b1;
         wbm_stb_o = 1'b1;
         wbm_we_o  = !is_read;
         wbm_sel_o = 4'hF;
         wbm_adr_o = ADDR_WIDTH'({addr, 2'b00});
         wbm_dat_o = (phase == P0_W) ? pattern(addr) :
                     (phase == P1_W) ? ~pattern(addr) : 32'd0;
      end
   end

   // Address generator control: load 0 at start and P0->P1, else step in GAP.
   always_comb begin
      ag_load     = 1'b0;
      ag_load_val = 8'd0;
      ag_step     = 1'b0;
      ag_up       = (phase != P2_R);
      if (start_test) begin
         ag_load = 1'b1;
      end else if (state == GAP) begin
         case (phase)
            P0_W:    if (ag_last) ag_load = 1'b1; else ag_step = 1'b1;
            P1_R:    ag_step = 1'b0;
            P1_W:    ag_step = !ag_last;
            P2_R:    ag_step = !ag_last;
            default: ag_step = 1'b0;
         endcase
      end
   end

   // Phase sequencing and per-access timeout counter.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         phase <= P0_W;
         tcnt  <= 4'd0;
      end else begin
         tcnt <= ((state == ACCESS) && !wbm_ack_i) ? tcnt + 4'd1 : 4'd0;
         if (start_test) begin
            phase <= P0_W;
         end else if (state == GAP) begin
            case (phase)
               P0_W:    if (ag_last) phase <= P1_R;
               P1_R:    phase <= P1_W;
               P1_W:    phase <= ag_last ? P2_R : P1_R;
               default: phase <= phase;
            endcase
         end
      end
   end

   // Result registers: first miscompare wins; a timeout overrides the address.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         err_seen    <= 1'b0;
         timeout_r   <= 1'b0;
         fail_addr_r <= 8'd0;
         fail_data_r <= 32'd0;
      end else if (start_test) begin
         err_seen    <= 1'b0;
         timeout_r   <= 1'b0;
         fail_addr_r <= 8'd0;
         fail_data_r <= 32'd0;
      end else if (miscompare && !err_seen) begin
         err_seen    <= 1'b1;
         fail_addr_r <= addr;
         fail_data_r <= wbm_dat_i;
      end else if (tmo_hit) begin
         timeout_r   <= 1'b1;
         fail_addr_r <= addr;
         fail_data_r <= 32'd0;
      end
   end

`ifdef WB_RAM_BIST_ERRCNT_EN
   logic [10:0] err_count_r;

   // Saturating count of every miscompare in the run.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)                              err_count_r <= 11'd0;
      else if (start_test)                          err_count_r <= 11'd0;
      else if (miscompare && (err_count_r != 11'h7FF)) err_count_r <= err_count_r + 11'd1;
   end

   assign err_count_o = err_count_r;
`endif

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Self-checking bench for wb_ram_bist_master: a Wishbone RAM model acking
// two cycles after stb, a scoreboard of expected test results popped when
// done_o rises, and a bus monitor checking every access.
module tb_wb_ram_bist_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, tmo;
   logic [7:0]  fail_addr;
   logic [31:0] fail_data;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [9:0]  adr;
   logic [31:0] dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = 32'd0;
`ifdef WB_RAM_BIST_ERRCNT_EN
   logic [10:0] err_count;
`endif

   wb_ram_bist_master #(.ADDR_WIDTH(10), .TIMEOUT(4'd15)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .timeout_o   (tmo),
      .fail_addr_o (fail_addr),
      .fail_data_o (fail_data),
`ifdef WB_RAM_BIST_ERRCNT_EN
      .err_count_o (err_count),
`endif
      .wbm_cyc_o   (cyc),
      .wbm_stb_o   (stb),
      .wbm_we_o    (we),
      .wbm_sel_o   (sel),
      .wbm_adr_o   (adr),
      .wbm_dat_o   (dat_o),
      .wbm_ack_i   (ack),
      .wbm_dat_i   (dat_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {a, a, a, a} ^ 32'hA5A5_A5A5;
   endfunction

   // ---------------- RAM model ----------------
   logic [31:0] mem [256];
   logic        ack_en     = 1'b1;
   logic        stuck_en   = 1'b0;
   logic        corrupt_en = 1'b0;

   function automatic logic [31:0] rd_val(input logic [7:0] a);
      logic [31:0] v;
      v = mem[a];
      if (stuck_en && a == 8'h40) v = v | 32'h8;
      if (corrupt_en && (a == 8'h10 || a == 8'h80 || a == 8'hFE)) v = v ^ 32'h1;
      return v;
   endfunction

   always @(posedge clk) begin
      if (cyc && stb && !ack && ack_en) begin
         ack <= 1'b1;
         if (we) mem[adr[9:2]] <= dat_o;
         else    dat_i <= rd_val(adr[9:2]);
      end else begin
         ack <= 1'b0;
      end
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        pass;
      logic        tmo;
      logic [7:0]  faddr;
      logic [31:0] fdata;
      int          lat;
      int          n_acc;
      int          errs;
   } exp_t;

   exp_t sb_q[$];
   int   start_edge = 0;
   int   acc_idx    = 0;

   function automatic void exp_access(input int idx, output logic e_we,
                                      output logic [9:0] e_adr, output logic [31:0] e_dat);
      logic [7:0] a;
      int j;
      if (idx < 256) begin
         a = 8'(idx); e_we = 1'b1; e_dat = pat(a);
      end else if (idx < 768) begin
         j = idx - 256;
         a = 8'(j / 2); e_we = (j % 2) == 1; e_dat = e_we ? ~pat(a) : 32'd0;
      end else begin
         a = 8'(1023 - idx); e_we = 1'b0; e_dat = 32'd0;
      end
      e_adr = {a, 2'b00};
   endfunction

   // Monitor: bus protocol on every access, results whenever done_o rises.
   initial begin
      logic        p_cyc = 1'b0, p_we = 1'b0, p_busy = 1'b0, p_done = 1'b0, first = 1'b1;
      logic [9:0]  p_adr = '0;
      logic [31:0] p_dat = '0;
      int          low_run = 0;
      logic        e_we;
      logic [9:0]  e_adr;
      logic [31:0] e_dat;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (busy && !p_busy) begin
            check("start_to_access", 64'(cyc_cnt), 64'(start_edge));
            acc_idx = 0;
            first   = 1'b1;
         end
         if (stb) check("stb_with_cyc", 64'(cyc), 64'd1);
         if (cyc && !p_cyc) begin
            if (!first) check("gap_len", 64'(low_run), 64'd1);
            first = 1'b0;
            exp_access(acc_idx, e_we, e_adr, e_dat);
            check("acc_adr", 64'(adr), 64'(e_adr));
            check("acc_we",  64'(we),  64'(e_we));
            check("acc_dat", 64'(dat_o), 64'(e_dat));
            check("acc_sel", 64'(sel), 64'hF);
            acc_idx++;
         end else if (cyc && p_cyc) begin
            check("acc_stable", {21'd0, p_we, p_adr, p_dat}, {21'd0, we, adr, dat_o});
         end
         low_run = cyc ? 0 : low_run + 1;
         if (done && !p_done) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc_cnt);
            end else begin
               e = sb_q.pop_front();
               check("pass",      64'(pass), 64'(e.pass));
               check("timeout",   64'(tmo),  64'(e.tmo));
               check("fail_addr", 64'(fail_addr), 64'(e.faddr));
               check("fail_data", 64'(fail_data), 64'(e.fdata));
               check("latency",   64'(cyc_cnt - start_edge), 64'(e.lat));
               check("n_access",  64'(acc_idx), 64'(e.n_acc));
               check("bus_idle",  {62'd0, cyc, stb}, 64'd0);
               check("busy_low",  64'(busy), 64'd0);
`ifdef WB_RAM_BIST_ERRCNT_EN
               check("err_count", 64'(err_count), 64'(e.errs));
`endif
            end
         end
         p_cyc = cyc; p_we = we; p_adr = adr; p_dat = dat_o;
         p_busy = busy; p_done = done;
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_start(input bit push, input exp_t e);
      @(negedge clk);
      if (push) sb_q.push_back(e);
      start_edge = cyc_cnt + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_result(input string name);
      for (int i = 0; i < 5000 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_wait: got no done_o within budget, want done_o", name);
         sb_q.delete();
      end else begin
         repeat (3) @(negedge clk);
         check({name, "_done_held"}, 64'(done), 64'd1);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, {39'd0, busy, done, pass, tmo, cyc, stb, we, sel, adr, 8'd0}, 64'd0);
      check({name, "_fail"}, {24'd0, fail_addr, fail_data}, 64'd0);
      check({name, "_dat"}, 64'(dat_o), 64'd0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   exp_t e_pass, e_stuck, e_tmo, e_cnt;

   initial begin
      e_pass  = '{pass: 1'b1, tmo: 1'b0, faddr: 8'h00, fdata: 32'h0, lat: 3072, n_acc: 1024, errs: 0};
`ifdef WB_RAM_BIST_ERRCNT_EN
      e_stuck = '{pass: 1'b0, tmo: 1'b0, faddr: 8'h40, fdata: 32'hE5E5_E5ED, lat: 3072, n_acc: 1024, errs: 1};
`else
      e_stuck = '{pass: 1'b0, tmo: 1'b0, faddr: 8'h40, fdata: 32'hE5E5_E5ED, lat: 1154, n_acc: 385, errs: 0};
`endif
      e_tmo   = '{pass: 1'b0, tmo: 1'b1, faddr: 8'h00, fdata: 32'h0, lat: 16, n_acc: 1, errs: 0};
      e_cnt   = '{pass: 1'b0, tmo: 1'b0, faddr: 8'h10, fdata: 32'hB5B5_B5B4, lat: 3072, n_acc: 1024, errs: 6};

      clear_mem();
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");

      // Ideal RAM, with a start pulse mid-test that must be ignored.
      run_start(1'b1, e_pass);
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_result("ideal");

      // Bit 3 of word 0x40 stuck at 1.
      clear_mem();
      stuck_en = 1'b1;
      run_start(1'b1, e_stuck);
      wait_result("stuck");
      stuck_en = 1'b0;

      // Slave never acks.
      ack_en = 1'b0;
      run_start(1'b1, e_tmo);
      wait_result("no_ack");
      ack_en = 1'b1;

      // Reset asserted mid-P1: no result, everything drops asynchronously.
      run_start(1'b0, e_pass);
      for (int i = 0; i < 3000 && acc_idx < 400; i++) @(negedge clk);
      check("reached_p1", 64'(acc_idx >= 400), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_start(1'b1, e_pass);
      wait_result("post_reset");

`ifdef WB_RAM_BIST_ERRCNT_EN
      corrupt_en = 1'b1;
      run_start(1'b1, e_cnt);
      wait_result("err_count");
      corrupt_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, want end of test");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_ram_bist_master.md
# wb_ram_bist_master

Wishbone classic initiator that runs a March-style self-test on a 32-bit, 256-word RAM through the Wishbone slave port of the dual-port OpenRAM wrapper. It is used at bring-up and in the test harness to prove the write path, byte-mask path and readback path from the Wishbone side. On `start_i` it issues 1024 single accesses, compares every readback, and reports pass/fail with the first failing address and data.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: Wishbone byte-address width. The word index sits in bits [9:2].
- `TIMEOUT`, 15: maximum cycles to wait for `ack` on one access, 4-bit range 1..15.

Ports:
- `wb_clk_i`  in  1: single clock.
- `wb_rst_n_i`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: pulse or level; sampled only in IDLE or DONE.
- `busy_o`  out  1: test in progress.
- `done_o`  out  1: result valid; held until the next start.
- `pass_o`  out  1: no miscompare and no timeout; valid when `done_o` is high.
- `timeout_o`  out  1: aborted because `ack` did not arrive.
- `fail_addr_o`  out  8: word index of the first failure.
- `fail_data_o`  out  32: data read at the first miscompare.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each.
- `wbm_sel_o`  out  4.
- `wbm_adr_o`  out  ADDR_WIDTH.
- `wbm_dat_o`  out  32.
- `wbm_ack_i`  in  1.
- `wbm_dat_i`  in  32.

## Operation
- Pattern: P(a) = {4{a[7:0]}} ^ 32'hA5A5_A5A5.
- Phases, executed in order:
  - P0_W: ascending a = 0..255, write P(a).
  - P1_R then P1_W, per address, ascending: read and expect P(a), then write ~P(a).
  - P2_R: descending a = 255..0, read and expect ~P(a).
- Every access uses `wbm_sel_o` = 4'hF and `wbm_adr_o` = {a, 2'b00}, zero-extended to ADDR_WIDTH.
- FSM states and transitions:
  - IDLE: `start_i` → ACCESS, with phase = P0_W, a = 0, results cleared.
  - ACCESS: cyc = stb = 1. On `ack`, go to GAP. On timeout, go to DONE.
  - GAP: cyc = stb = 0 for exactly one cycle, then advance the phase/address and go to ACCESS. After the last P2_R access, go to DONE instead.
  - DONE: `done_o` = 1. `start_i` → ACCESS with a fresh test.
- Compare happens on the `ack` cycle of a read. The first miscompare latches `fail_addr_o` and `fail_data_o` and clears pass. The test stops, going to DONE instead of GAP.
- Timeout: a 4-bit counter runs in ACCESS. When it reaches TIMEOUT with no `ack`:
  - drop cyc/stb;
  - set `timeout_o` = 1 and `pass_o` = 0;
  - set `fail_addr_o` = current a and `fail_data_o` = 0;
  - go to DONE.
- `start_i` while `busy_o` is high is ignored.
- `wbm_dat_o` and `wbm_we_o` are stable for the whole ACCESS state. `wbm_dat_o` = 0 on reads.

## Timing
- Reset values: all outputs 0, state IDLE. Reset is asynchronous: cyc/stb drop immediately, even mid-access, and no result is reported.
- Start sampled at edge k → cyc/stb high from edge k+1.
- With a slave acking L cycles after stb rises, each access takes L+1 cycles including the GAP cycle.
- For a full passing test, `done_o` rises one cycle after the final `ack`, i.e. 1 + 1024·(L+1) − 1 cycles after the start edge.
- `ack` in GAP or IDLE is ignored.
- Address wrap: `a` never wraps. Terminal counts 255 (ascending) and 0 (descending) end the phase.

## Configuration
- `WB_RAM_BIST_ERRCNT_EN`:
  - Defined: adds output `err_count_o` [10:0]. A miscompare does not stop the test; all 512 reads are checked and `err_count_o` increments, saturating at 2047. `fail_*` still hold the first failure. Timeout still aborts.
  - Undefined: stop on the first miscompare, and the port is absent.

## Structure
- Package `wb_ram_bist_pkg`:
  - state enum (IDLE, ACCESS, GAP, DONE);
  - phase enum (P0_W, P1_R, P1_W, P2_R);
  - `PATTERN_KEY` = 32'hA5A5_A5A5;
  - function `pattern(a)`.
- One sub-module, `wb_ram_bist_addr_gen`: 8-bit up/down counter with load, step, and `last` flag.

## Test plan
- Ideal RAM model acking at L=2: start → 1024 accesses; `done_o` at cycle 3072 after the start edge, `pass_o` = 1, `timeout_o` = 0.
- Model with bit 3 of word 0x40 stuck at 1: start → `pass_o` = 0, `fail_addr_o` = 8'h40, `fail_data_o` = P(0x40) | 32'h8 (P1_R read).
- Slave never acks: start → `done_o` after TIMEOUT+1 cycles, `timeout_o` = 1, `fail_addr_o` = 0, cyc/stb low.
- Reset asserted mid-P1: cyc/stb low asynchronously, all outputs 0. A later start runs a full passing test.
- Bus protocol check on every access: stb only with cyc; `adr`/`dat`/`we` stable until ack; one idle cycle between accesses; the P2_R address sequence is 0x3FC down to 0x000.
- With `WB_RAM_BIST_ERRCNT_EN`, 3 corrupted words, each failing in P1_R and P2_R → `err_count_o` = 6, and all 1024 accesses complete.
